sdram_line_fill_arbiter: RTL and testbench

//  Sits between the instruction cache fill port, the data-memory port and the SDRAM controller word port.

---
 rtl/sdram_line_fill_arbiter_if.sv | 46 ++++
 rtl/sdram_line_fill_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sdram_line_fill_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_line_fill_arbiter_if.sv
// Bus bundle for sdram_line_fill_arbiter: icache fill port, dmem word port
// and SDRAM controller word port. The arbiter uses the slave view; the
// environment driving it (caches, controller model) uses the master view.
interface sdram_line_fill_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              icache_ren;
    logic [31:0]       icache_addr;
    logic [31:0]       icache_data;
    logic              icache_ack;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  icache_ren, icache_addr,
        output icache_data, icache_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output icache_ren, icache_addr,
        input  icache_data, icache_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/sdram_line_fill_arbiter.sv
// sdram_line_fill_arbiter
// Arbitrates the SDRAM controller word port between icache line fills and
// single-word dmem accesses. A fill gathers LINE_WORDS words into a local
// line buffer (at most MAX_OUT reads in flight) and then replays the whole
// line to the icache as one gap-free burst. Conflicting requests in IDLE are
// resolved round-robin.
// Optional build macro: FILL_PERF_CNT_EN adds perf_fills / perf_fill_cycles.
module sdram_line_fill_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int LINE_WORDS = 16,
    parameter int MAX_OUT    = 4
) (
    input  logic sdram_clk,
    input  logic reset_n,
    sdram_line_fill_arbiter_if.slave bus
`ifdef FILL_PERF_CNT_EN
    ,
    output logic [31:0] perf_fills,
    output logic [31:0] perf_fill_cycles
`endif
);
    localparam int LW_B = $clog2(LINE_WORDS);
    localparam int CW   = LW_B + 1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        FILL_COLLECT = 3'd1,
        FILL_STREAM  = 3'd2,
        D_ISSUE      = 3'd3,
        D_WAIT       = 3'd4
    } state_t;

    localparam logic GNT_ICACHE = 1'b0;
    localparam logic GNT_DMEM   = 1'b1;

    // Line-aligned base of a word address.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        line_base = a & ~ADDR_W'(LINE_WORDS - 1);
    endfunction

    state_t            state_r;
    logic              last_grant_r;
    logic [ADDR_W-1:0] base_r;
    logic [CW-1:0]     iss_cnt_r;
    logic [CW-1:0]     rcv_cnt_r;
    logic [CW-1:0]     str_cnt_r;
    logic [31:0]       line_buf_r [LINE_WORDS];

    logic [31:0]       icache_data_r;
    logic              icache_ack_r;
    logic [31:0]       dmem_rdata_r;
    logic              dmem_ack_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [3:0]        mem_be_r;

    logic              accept_s;
    logic              rv_fill_s;
    logic [CW-1:0]     iss_next_s;
    logic [CW-1:0]     rcv_next_s;
    logic [CW-1:0]     inflight_s;
    logic              fill_req_next_s;
    logic [ADDR_W-1:0] fill_addr_next_s;
    logic              ireq_s;
    logic              dreq_s;
    logic              pick_icache_s;

    // Next-cycle fill counters and request qualifiers; mem_req is registered,
    // so its next value is derived from the post-update counters.
    always_comb begin
        accept_s         = mem_req_r & bus.mem_ready;
        rv_fill_s        = (state_r == FILL_COLLECT) && bus.mem_rvalid && (rcv_cnt_r != iss_cnt_r);
        iss_next_s       = iss_cnt_r + CW'(accept_s);
        rcv_next_s       = rcv_cnt_r + CW'(rv_fill_s);
        inflight_s       = iss_next_s - rcv_next_s;
        fill_req_next_s  = (iss_next_s < CW'(LINE_WORDS)) && (inflight_s < CW'(MAX_OUT));
        fill_addr_next_s = base_r | ADDR_W'(iss_next_s[LW_B-1:0]);
        // A request is ignored while its own ack is still visible to the requester.
        ireq_s           = bus.icache_ren & ~icache_ack_r;
        dreq_s           = bus.dmem_req & ~dmem_ack_r;
        pick_icache_s    = ireq_s & (~dreq_s | (last_grant_r == GNT_DMEM));
    end

    // Main control FSM with registered outputs.
    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= IDLE;
            last_grant_r     <= GNT_DMEM;
            base_r           <= '0;
            iss_cnt_r        <= '0;
            rcv_cnt_r        <= '0;
            str_cnt_r        <= '0;
            icache_data_r    <= 32'h0000_0000;
            icache_ack_r     <= 1'b0;
            dmem_rdata_r     <= 32'h0000_0000;
            dmem_ack_r       <= 1'b0;
            mem_req_r        <= 1'b0;
            mem_we_r         <= 1'b0;
            mem_addr_r       <= '0;
            mem_wdata_r      <= 32'h0000_0000;
            mem_be_r         <= 4'h0;
`ifdef FILL_PERF_CNT_EN
            perf_fills       <= 32'h0000_0000;
            perf_fill_cycles <= 32'h0000_0000;
`endif
        end else begin
            dmem_ack_r <= 1'b0;
`ifdef FILL_PERF_CNT_EN
            if (state_r == FILL_COLLECT || state_r == FILL_STREAM) begin
                perf_fill_cycles <= perf_fill_cycles + 32'd1;
            end
`endif
            case (state_r)
                IDLE: begin
                    if (pick_icache_s) begin
                        state_r      <= FILL_COLLECT;
                        last_grant_r <= GNT_ICACHE;
                        base_r       <= line_base(bus.icache_addr[ADDR_W-1:0]);
                        iss_cnt_r    <= '0;
                        rcv_cnt_r    <= '0;
                        str_cnt_r    <= '0;
                        mem_req_r    <= 1'b1;
                        mem_we_r     <= 1'b0;
                        mem_addr_r   <= line_base(bus.icache_addr[ADDR_W-1:0]);
                        mem_wdata_r  <= 32'h0000_0000;
                        mem_be_r     <= 4'hF;
                    end else if (dreq_s) begin
                        state_r      <= D_ISSUE;
                        last_grant_r <= GNT_DMEM;
                        mem_req_r    <= 1'b1;
                        mem_we_r     <= bus.dmem_we;
                        mem_addr_r   <= bus.dmem_addr;
                        mem_wdata_r  <= bus.dmem_wdata;
                        mem_be_r     <= bus.dmem_we ? bus.dmem_be : 4'hF;
                    end
                end
                FILL_COLLECT: begin
                    iss_cnt_r  <= iss_next_s;
                    rcv_cnt_r  <= rcv_next_s;
                    mem_req_r  <= fill_req_next_s;
                    mem_addr_r <= fill_addr_next_s;
                    if (rcv_next_s == CW'(LINE_WORDS)) begin
                        state_r       <= FILL_STREAM;
                        icache_ack_r  <= 1'b1;
                        icache_data_r <= line_buf_r[0];
                        str_cnt_r     <= CW'(1);
                    end
                end
                FILL_STREAM: begin
                    if (str_cnt_r == CW'(LINE_WORDS)) begin
                        state_r      <= IDLE;
                        icache_ack_r <= 1'b0;
`ifdef FILL_PERF_CNT_EN
                        perf_fills   <= perf_fills + 32'd1;
`endif
                    end else begin
                        icache_data_r <= line_buf_r[str_cnt_r[LW_B-1:0]];
                        str_cnt_r     <= str_cnt_r + CW'(1);
                    end
                end
                D_ISSUE: begin
                    if (accept_s) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (mem_we_r) begin
                            dmem_ack_r <= 1'b1;
                            state_r    <= IDLE;
                        end else begin
                            state_r    <= D_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    if (bus.mem_rvalid) begin
                        dmem_rdata_r <= bus.mem_rdata;
                        dmem_ack_r   <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer capture; contents are don't-care after reset.
    always_ff @(posedge sdram_clk) begin
        if (rv_fill_s) begin
            line_buf_r[rcv_cnt_r[LW_B-1:0]] <= bus.mem_rdata;
        end
    end

    assign bus.icache_data = icache_data_r;
    assign bus.icache_ack  = icache_ack_r;
    assign bus.dmem_rdata  = dmem_rdata_r;
    assign bus.dmem_ack    = dmem_ack_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.mem_be      = mem_be_r;
endmodule

// File: tb/tb_sdram_line_fill_arbiter.sv
// Directed bench for sdram_line_fill_arbiter with a small SDRAM controller
// responder (fixed read latency, in-order returns).
module tb_sdram_line_fill_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    sdram_line_fill_arbiter_if #(.ADDR_W(21)) bus ();

`ifdef FILL_PERF_CNT_EN
    logic [31:0] perf_fills;
    logic [31:0] perf_fill_cycles;
`endif

    sdram_line_fill_arbiter #(.ADDR_W(21), .LINE_WORDS(16), .MAX_OUT(4)) dut (
        .sdram_clk (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave)
`ifdef FILL_PERF_CNT_EN
        ,
        .perf_fills       (perf_fills),
        .perf_fill_cycles (perf_fill_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller responder state
    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;
    rd_t         rq[$];
    logic [21:0] acc_q[$];
    int          rd_lat = 2;
    int          rv_count = 0;
    int          last_rv_cyc = 0;
    int          max_out_seen = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    int          first_ack_cyc = 0;

    function automatic logic [31:0] mem_data(input logic [20:0] a);
        return 32'hA500_0000 | {11'h000, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Controller model: acts 1 time unit after each falling edge.
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                rq.delete();
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 32'h0;
            end else begin
                if (bus.mem_req && bus.mem_ready && !bus.mem_we) begin
                    if (rq.size() + 1 > max_out_seen) max_out_seen = rq.size() + 1;
                end
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rq[0].data;
                    void'(rq.pop_front());
                    rv_count++;
                    last_rv_cyc = cyc;
                end else begin
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata  = 32'h0;
                end
                if (bus.mem_req && bus.mem_ready) begin
                    acc_q.push_back({bus.mem_we, bus.mem_addr});
                    if (!bus.mem_we)
                        rq.push_back('{data: (ovr_en ? ovr_data : mem_data(bus.mem_addr)), due: cyc + rd_lat});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Requests a fill, waits for the burst and checks all words.
    task automatic do_fill(input string tag, input logic [31:0] a, input int lat);
        int          waitc;
        int          n;
        logic [20:0] base;
        rd_lat = lat;
        base = a[20:0] & ~21'h00000F;
        bus.icache_ren  = 1'b1;
        bus.icache_addr = a;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!bus.icache_ack && waitc < 400);
        first_ack_cyc = cyc;
        check({tag, "_ack_seen"}, {31'h0, bus.icache_ack}, 32'h1);
        bus.icache_ren = 1'b0;
        n = 0;
        while (bus.icache_ack && n < 20) begin
            check($sformatf("%s_w%0d", tag, n), bus.icache_data, mem_data(base + 21'(n)));
            n++;
            @(negedge clk);
        end
        check({tag, "_burst_len"}, 32'(n), 32'd16);
    endtask

    initial begin
        int w;
        int n_ack;
        logic dack_early;

        reset_n         = 1'b0;
        bus.icache_ren  = 1'b0;
        bus.icache_addr = 32'h0;
        bus.dmem_req    = 1'b0;
        bus.dmem_we     = 1'b0;
        bus.dmem_addr   = 21'h0;
        bus.dmem_wdata  = 32'h0;
        bus.dmem_be     = 4'h0;
        bus.mem_ready   = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_icache_ack",  {31'h0, bus.icache_ack}, 32'h0);
        check("rst_icache_data", bus.icache_data, 32'h0);
        check("rst_dmem_ack",    {31'h0, bus.dmem_ack}, 32'h0);
        check("rst_dmem_rdata",  bus.dmem_rdata, 32'h0);
        check("rst_mem_req",     {31'h0, bus.mem_req}, 32'h0);
        check("rst_mem_addr",    {11'h0, bus.mem_addr}, 32'h0);
        check("rst_mem_be",      {28'h0, bus.mem_be}, 32'h0);
        reset_n = 1'b1;

        // 1: basic fill, rvalid 2 cycles after accept
        acc_q.delete();
        max_out_seen = 0;
        do_fill("t1", 32'h0000_1234, 2);
        check("t1_n_acc", 32'(acc_q.size()), 32'd16);
        for (int k = 0; k < 16; k++)
            check($sformatf("t1_addr%0d", k), {10'h0, acc_q[k]}, {11'h0, 21'h001230 + 21'(k)});
        check("t1_inflight_le4", {31'h0, (max_out_seen <= 4)}, 32'h1);
        check("t1_ack_latency", 32'(first_ack_cyc - last_rv_cyc), 32'd1);

        // 2: simultaneous requests after reset -> fill first, then dmem on next conflict
        do_reset();
        acc_q.delete();
        rd_lat = 2;
        @(negedge clk);
        bus.icache_ren  = 1'b1;
        bus.icache_addr = 32'h0000_0100;
        bus.dmem_req    = 1'b1;
        bus.dmem_we     = 1'b1;
        bus.dmem_addr   = 21'h000077;
        bus.dmem_wdata  = 32'h1111_2222;
        bus.dmem_be     = 4'hF;
        dack_early = 1'b0;
        w = 0;
        while (!bus.icache_ack && w < 400) begin
            @(negedge clk);
            w++;
            if (bus.dmem_ack) dack_early = 1'b1;
        end
        check("t2_fill_ack", {31'h0, bus.icache_ack}, 32'h1);
        bus.icache_ren = 1'b0;
        w = 0;
        while (bus.icache_ack && w < 40) begin
            @(negedge clk);
            w++;
            if (bus.dmem_ack) dack_early = 1'b1;
        end
        check("t2_no_dmem_during_fill", {31'h0, dack_early}, 32'h0);
        bus.icache_ren  = 1'b1;
        bus.icache_addr = 32'h0000_0200;
        w = 0;
        while (!bus.dmem_ack && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("t2_dmem_ack", {31'h0, bus.dmem_ack}, 32'h1);
        check("t2_no_icache_ack_at_dack", {31'h0, bus.icache_ack}, 32'h0);
        bus.dmem_req = 1'b0;
        w = 0;
        while (!bus.icache_ack && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("t2_fill2_ack", {31'h0, bus.icache_ack}, 32'h1);
        bus.icache_ren = 1'b0;
        w = 0;
        while (bus.icache_ack && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("t2_acc0",  {10'h0, acc_q[0]},  {11'h0, 21'h000100});
        check("t2_acc16", {10'h0, acc_q[16]}, {10'h0, 1'b1, 21'h000077});
        check("t2_acc17", {10'h0, acc_q[17]}, {11'h0, 21'h000200});

        // 3: dmem write with mem_ready low for 3 cycles
        acc_q.delete();
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = 1'b1;
        bus.dmem_addr  = 21'h000042;
        bus.dmem_wdata = 32'hCAFE_F00D;
        bus.dmem_be    = 4'b0011;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.mem_req && w < 20);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_req%0d", i),   {31'h0, bus.mem_req}, 32'h1);
            check($sformatf("t3_we%0d", i),    {31'h0, bus.mem_we}, 32'h1);
            check($sformatf("t3_addr%0d", i),  {11'h0, bus.mem_addr}, 32'h0000_0042);
            check($sformatf("t3_be%0d", i),    {28'h0, bus.mem_be}, 32'h3);
            check($sformatf("t3_wdata%0d", i), bus.mem_wdata, 32'hCAFE_F00D);
            check($sformatf("t3_noack%0d", i), {31'h0, bus.dmem_ack}, 32'h0);
            @(negedge clk);
        end
        check("t3_req_held", {31'h0, bus.mem_req}, 32'h1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("t3_ack_after_accept", {31'h0, bus.dmem_ack}, 32'h1);
        check("t3_req_dropped", {31'h0, bus.mem_req}, 32'h0);
        bus.dmem_req = 1'b0;
        @(negedge clk);
        check("t3_ack_one_cycle", {31'h0, bus.dmem_ack}, 32'h0);

        // 4: dmem read, rvalid 5 cycles after accept
        acc_q.delete();
        rd_lat   = 5;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        bus.dmem_req  = 1'b1;
        bus.dmem_we   = 1'b0;
        bus.dmem_addr = 21'h000055;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.dmem_ack && w < 50);
        check("t4_ack", {31'h0, bus.dmem_ack}, 32'h1);
        check("t4_ack_latency", 32'(cyc - last_rv_cyc), 32'd1);
        check("t4_rdata", bus.dmem_rdata, 32'hDEAD_BEEF);
        check("t4_acc0", {10'h0, acc_q[0]}, {11'h0, 21'h000055});
        bus.dmem_req = 1'b0;
        ovr_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_rdata_hold", bus.dmem_rdata, 32'hDEAD_BEEF);
        check("t4_ack_low", {31'h0, bus.dmem_ack}, 32'h0);

        // 5: reset after 7 words returned
        rv_count = 0;
        rd_lat = 2;
        bus.icache_ren  = 1'b1;
        bus.icache_addr = 32'h0000_2000;
        w = 0;
        while (rv_count < 7 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("t5_seven_words", 32'(rv_count), 32'd7);
        reset_n = 1'b0;
        #1;
        check("t5_rst_mem_req",     {31'h0, bus.mem_req}, 32'h0);
        check("t5_rst_mem_addr",    {11'h0, bus.mem_addr}, 32'h0);
        check("t5_rst_icache_ack",  {31'h0, bus.icache_ack}, 32'h0);
        check("t5_rst_dmem_ack",    {31'h0, bus.dmem_ack}, 32'h0);
        check("t5_rst_dmem_rdata",  bus.dmem_rdata, 32'h0);
        check("t5_rst_mem_be",      {28'h0, bus.mem_be}, 32'h0);
        bus.icache_ren = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_ack = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.icache_ack) n_ack++;
        end
        check("t5_no_ack_after_reset", 32'(n_ack), 32'd0);
        max_out_seen = 0;
        do_fill("t5", 32'h0000_3005, 6);
        check("t5_inflight_max", 32'(max_out_seen), 32'd4);

`ifdef FILL_PERF_CNT_EN
        // 6: three fills since the last reset
        do_fill("t6a", 32'h0000_4000, 2);
        do_fill("t6b", 32'h0000_4010, 3);
        @(negedge clk);
        check("t6_perf_fills", perf_fills, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end
endmodule
